// File: rtl/stopwatch_lap_pkg.sv
// Shared definitions for the timer-mode stopwatch: mode encodings used by the
// digital clock, stopwatch state encoding, the packed time word, and a width
// helper for counters and pointers.
package stopwatch_lap_pkg;

  // Mode encodings shared with the rest of the digital clock
  localparam logic [1:0] M1_CLOCK       = 2'b00;
  localparam logic [1:0] M1_TIMER       = 2'b10;
  localparam logic [1:0] M2_TIMER_G     = 2'b00;
  localparam logic [1:0] M2_TIMER_START = 2'b01;
  localparam logic [1:0] M2_TIMER_STOP  = 2'b10;

  // Width of one captured time word: min(6) + sec(6) + secc(4)
  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [3:0] secc;
  } sw_time_t;

  // Number of bits needed to hold the unsigned value 'value' (at least 1)
  function automatic int bits_required(input int value);
    int n;
    n = 1;
    while ((value >> n) != 0) n++;
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_lap_lap_fifo.sv
// First-word-fall-through FIFO holding captured lap times. The head entry is
// visible whenever the FIFO is non-empty; reads return zero when empty.
module lap_fifo
  import stopwatch_lap_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             push,
  input  logic                             pop,
  input  logic [WIDTH-1:0]                 wdata,
  output logic [WIDTH-1:0]                 head,
  output logic                             full,
  output logic [bits_required(DEPTH)-1:0]  count
);

  localparam int PTR_W = bits_required(DEPTH - 1);
  localparam int CNT_W = bits_required(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A pop on an empty FIFO is ignored; a push while full only lands if the
  // same edge frees a slot by popping.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; clear empties the FIFO like reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; when full with a simultaneous pop, the write slot equals
  // the read slot, and the old head is consumed on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count, and empty reads are forced to zero, so stale words never leak.
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Timer-mode stopwatch: run/pause/clear state machine driven by the mode
// inputs, tenths prescaler, min:sec.tenths carry chain with wrap or saturate
// overflow policy, and a lap-capture FIFO feeding the display mux.
module stopwatch_lap
  import stopwatch_lap_pkg::*;
#(
  parameter int CLOCKS4SECC = 10,
  parameter int MAX_MIN     = 59,
  parameter int LAP_DEPTH   = 4,
  parameter int SATURATE    = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           mode1,
  input  logic [1:0]                           mode2,
  input  logic                                 lap_req,
  input  logic                                 lap_rd,
  output logic [5:0]                           min_sw,
  output logic [5:0]                           sec_sw,
  output logic [3:0]                           secc_sw,
  output logic [5:0]                           lap_min,
  output logic [5:0]                           lap_sec,
  output logic [3:0]                           lap_secc,
  output logic                                 lap_valid,
  output logic                                 lap_full,
  output logic [bits_required(LAP_DEPTH)-1:0]  lap_count,
  output logic                                 overflow
);

  localparam int PRE_W = bits_required(CLOCKS4SECC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCKS4SECC - 1);
  localparam logic [5:0]       MIN_LAST = 6'(MAX_MIN);

  sw_state_t         state_q;
  sw_state_t         state_next;
  sw_time_t          time_q;
  sw_time_t          time_next;
  logic [PRE_W-1:0]  presc_q;
  logic              clear;
  logic              run_en;
  logic              tick;
  logic              at_max;
  logic              push_en;
  logic [TIME_W-1:0] lap_head;

  // Decode the requested state from the current mode inputs
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = PAUSE;
    if (mode1 != M1_TIMER || mode2 == M2_TIMER_G) begin
      state_next = IDLE;
    end else if (mode2 == M2_TIMER_START) begin
      state_next = RUN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Heading into IDLE clears everything on this edge and wins over a tick or
  // a lap request arriving in the same cycle.
  assign clear   = (state_next == IDLE);
  assign run_en  = (state_q == RUN) && !clear && !((SATURATE != 0) && overflow);
  assign tick    = run_en && (presc_q == PRE_LAST);
  assign at_max  = (time_q.min == MIN_LAST) && (time_q.sec == 6'd59) &&
                   (time_q.secc == 4'd9);
  assign push_en = lap_req && (state_q != IDLE) && !clear;

  // Next time value on a tick: tenths -> seconds -> minutes -> overflow
  always_comb begin
    time_next = time_q;
    if (at_max) begin
      time_next = (SATURATE != 0) ? time_q : '0;
    end else if (time_q.secc != 4'd9) begin
      time_next.secc = time_q.secc + 4'd1;
    end else begin
      time_next.secc = 4'd0;
      if (time_q.sec != 6'd59) begin
        time_next.sec = time_q.sec + 6'd1;
      end else begin
        time_next.sec = 6'd0;
        time_next.min = time_q.min + 6'd1;
      end
    end
  end

  // Prescaler, running time and sticky overflow; PAUSE simply holds them
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc_q  <= '0;
      time_q   <= '0;
      overflow <= 1'b0;
    end else if (run_en) begin
      if (tick) begin
        presc_q <= '0;
        time_q  <= time_next;
        if (at_max) overflow <= 1'b1;
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

  assign min_sw  = time_q.min;
  assign sec_sw  = time_q.sec;
  assign secc_sw = time_q.secc;

  // Lap captures take the displayed (pre-edge) time
  lap_fifo #(
    .WIDTH (TIME_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push_en),
    .pop   (lap_rd),
    .wdata (time_q),
    .head  (lap_head),
    .full  (lap_full),
    .count (lap_count)
  );

  assign {lap_min, lap_sec, lap_secc} = lap_head;
  assign lap_valid = (lap_count != '0);

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a default-parameter instance for timing,
// pause, lap FIFO, IDLE and reset behaviour, plus a fast wrap/saturate pair
// (CLOCKS4SECC=2, MAX_MIN=1) so the overflow boundary is reachable quickly.
module tb_stopwatch_lap;
  import stopwatch_lap_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic       reset;
  logic [1:0] mode1, mode2;
  logic       lap_req, lap_rd;
  logic [5:0] min_sw, sec_sw, lap_min, lap_sec;
  logic [3:0] secc_sw, lap_secc;
  logic       lap_valid, lap_full, overflow;
  logic [2:0] lap_count;

  // Overflow pair signals (shared stimulus)
  logic [1:0] o_mode1, o_mode2;
  logic       o_lap_req, o_lap_rd;
  logic [5:0] w_min, w_sec, w_lmin, w_lsec, s_min, s_sec, s_lmin, s_lsec;
  logic [3:0] w_secc, w_lsecc, s_secc, s_lsecc;
  logic       w_valid, w_full, w_ovf, s_valid, s_full, s_ovf;
  logic [1:0] w_count, s_count;

  stopwatch_lap #(.CLOCKS4SECC(10), .MAX_MIN(59), .LAP_DEPTH(4), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .mode1(mode1), .mode2(mode2),
    .lap_req(lap_req), .lap_rd(lap_rd),
    .min_sw(min_sw), .sec_sw(sec_sw), .secc_sw(secc_sw),
    .lap_min(lap_min), .lap_sec(lap_sec), .lap_secc(lap_secc),
    .lap_valid(lap_valid), .lap_full(lap_full), .lap_count(lap_count),
    .overflow(overflow)
  );

  stopwatch_lap #(.CLOCKS4SECC(2), .MAX_MIN(1), .LAP_DEPTH(2), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .mode1(o_mode1), .mode2(o_mode2),
    .lap_req(o_lap_req), .lap_rd(o_lap_rd),
    .min_sw(w_min), .sec_sw(w_sec), .secc_sw(w_secc),
    .lap_min(w_lmin), .lap_sec(w_lsec), .lap_secc(w_lsecc),
    .lap_valid(w_valid), .lap_full(w_full), .lap_count(w_count),
    .overflow(w_ovf)
  );

  stopwatch_lap #(.CLOCKS4SECC(2), .MAX_MIN(1), .LAP_DEPTH(2), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .mode1(o_mode1), .mode2(o_mode2),
    .lap_req(o_lap_req), .lap_rd(o_lap_rd),
    .min_sw(s_min), .sec_sw(s_sec), .secc_sw(s_secc),
    .lap_min(s_lmin), .lap_sec(s_lsec), .lap_secc(s_lsecc),
    .lap_valid(s_valid), .lap_full(s_full), .lap_count(s_count),
    .overflow(s_ovf)
  );

  logic [15:0] main_time, lap_head, wrap_time, sat_time;
  assign main_time = {min_sw, sec_sw, secc_sw};
  assign lap_head  = {lap_min, lap_sec, lap_secc};
  assign wrap_time = {w_min, w_sec, w_secc};
  assign sat_time  = {s_min, s_sec, s_secc};

  int errors = 0;
  int checks = 0;
  logic [15:0] sb [$];

  function automatic logic [15:0] tt(input int m, input int s, input int c);
    return {6'(m), 6'(s), 4'(c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land on the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_main(input logic [15:0] target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (main_time == target) break;
      step(1);
    end
    check(tag, main_time, target);
  endtask

  // Request a lap while the display shows 'target'; a full FIFO drops it
  task automatic lap_at(input logic [15:0] target);
    wait_main(target, 300, "lap_wait");
    lap_req = 1'b1;
    if (sb.size() < 4) sb.push_back(target);
    step(1);
    lap_req = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] exp;
    exp = (sb.size() != 0) ? sb[0] : 16'h0;
    check(tag, lap_head, exp);
    lap_rd = 1'b1;
    step(1);
    lap_rd = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode1 = M1_CLOCK; mode2 = M2_TIMER_G; lap_req = 1'b0; lap_rd = 1'b0;
    o_mode1 = M1_CLOCK; o_mode2 = M2_TIMER_G; o_lap_req = 1'b0; o_lap_rd = 1'b0;
    @(negedge clk);
    step(3);

    // Reset state
    check("rst_time", main_time, tt(0, 0, 0));
    check("rst_head", lap_head, tt(0, 0, 0));
    check("rst_valid", lap_valid, 1'b0);
    check("rst_full", lap_full, 1'b0);
    check("rst_count", lap_count, 0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    step(2);

    // lap_req in IDLE is ignored
    lap_req = 1'b1;
    step(1);
    lap_req = 1'b0;
    check("idle_lap_count", lap_count, 0);
    check("idle_lap_valid", lap_valid, 1'b0);

    // START: one edge to enter RUN, then 100 prescaler edges = 10 ticks
    mode1 = M1_TIMER; mode2 = M2_TIMER_START;
    step(100);
    check("run_100", main_time, tt(0, 0, 9));
    step(1);
    check("run_101", main_time, tt(0, 1, 0));

    // PAUSE: the transition edge still counts once (prescaler 1), then holds
    mode2 = M2_TIMER_STOP;
    step(51);
    check("pause_hold", main_time, tt(0, 1, 0));

    // Resume: held partial count means the next tick needs only 9 RUN edges
    mode2 = M2_TIMER_START;
    step(9);
    check("resume_pre", main_time, tt(0, 1, 0));
    step(1);
    check("resume_tick", main_time, tt(0, 1, 1));

    // G sub-mode clears on the next edge
    mode2 = M2_TIMER_G;
    step(1);
    check("g_clear", main_time, tt(0, 0, 0));
    mode2 = M2_TIMER_START;

    // Five laps into a 4-deep FIFO; the fifth is dropped
    lap_at(tt(0, 0, 3));
    check("lap1_valid", lap_valid, 1'b1);
    check("lap1_head", lap_head, tt(0, 0, 3));
    lap_at(tt(0, 0, 5));
    lap_at(tt(0, 0, 7));
    lap_at(tt(0, 0, 9));
    check("lap4_full", lap_full, 1'b1);
    check("lap4_count", lap_count, sb.size());
    lap_at(tt(0, 1, 1));
    check("lap5_full", lap_full, 1'b1);
    check("lap5_count", lap_count, 4);
    for (int i = 0; i < 4; i++) pop_check("pop_order");
    check("drain_valid", lap_valid, 1'b0);
    check("drain_head", lap_head, tt(0, 0, 0));

    // Pop on empty is ignored
    lap_rd = 1'b1;
    step(1);
    lap_rd = 1'b0;
    check("pop_empty_count", lap_count, 0);

    // Refill, then push+pop on the same edge while full
    lap_at(tt(0, 1, 5));
    lap_at(tt(0, 1, 7));
    lap_at(tt(0, 1, 9));
    lap_at(tt(0, 2, 1));
    wait_main(tt(0, 2, 3), 300, "pp_full_wait");
    check("pp_full_head_before", lap_head, sb[0]);
    void'(sb.pop_front());
    sb.push_back(tt(0, 2, 3));
    lap_req = 1'b1; lap_rd = 1'b1;
    step(1);
    lap_req = 1'b0; lap_rd = 1'b0;
    check("pp_full_count", lap_count, 4);
    check("pp_full_full", lap_full, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("pp_full_order");

    // Push+pop on the same edge while empty: only the push happens
    wait_main(tt(0, 2, 7), 300, "pp_empty_wait");
    sb.push_back(tt(0, 2, 7));
    lap_req = 1'b1; lap_rd = 1'b1;
    step(1);
    lap_req = 1'b0; lap_rd = 1'b0;
    check("pp_empty_count", lap_count, 1);
    check("pp_empty_valid", lap_valid, 1'b1);
    pop_check("pp_empty_head");

    // Leaving TIMER with 3 laps stored clears on the next edge; a lap_req on
    // that same cycle loses to the clear
    lap_at(tt(0, 2, 9));
    lap_at(tt(0, 3, 1));
    lap_at(tt(0, 3, 3));
    check("three_laps", lap_count, 3);
    mode1 = M1_CLOCK; lap_req = 1'b1;
    step(1);
    lap_req = 1'b0;
    sb.delete();
    check("leave_count", lap_count, 0);
    check("leave_valid", lap_valid, 1'b0);
    check("leave_time", main_time, tt(0, 0, 0));
    check("main_no_ovf", overflow, 1'b0);

    // Overflow pair: run to 1:59.8, then one tick to max, one tick to overflow
    o_mode1 = M1_TIMER; o_mode2 = M2_TIMER_START;
    for (int i = 0; i < 3000; i++) begin
      if (wrap_time == tt(1, 59, 8)) break;
      step(1);
    end
    check("ovf_reach", wrap_time, tt(1, 59, 8));
    check("ovf_sat_reach", sat_time, tt(1, 59, 8));
    step(2);
    check("ovf_wrap_max", wrap_time, tt(1, 59, 9));
    check("ovf_wrap_flag0", w_ovf, 1'b0);
    check("ovf_sat_max", sat_time, tt(1, 59, 9));
    step(2);
    check("ovf_wrap_zero", wrap_time, tt(0, 0, 0));
    check("ovf_wrap_flag", w_ovf, 1'b1);
    check("ovf_sat_hold", sat_time, tt(1, 59, 9));
    check("ovf_sat_flag", s_ovf, 1'b1);
    step(10);
    check("ovf_wrap_cont", wrap_time, tt(0, 0, 5));
    check("ovf_sat_still", sat_time, tt(1, 59, 9));
    o_mode2 = M2_TIMER_G;
    step(1);
    check("g_wrap_time", wrap_time, tt(0, 0, 0));
    check("g_wrap_ovf", w_ovf, 1'b0);
    check("g_sat_time", sat_time, tt(0, 0, 0));
    check("g_sat_ovf", s_ovf, 1'b0);

    // Reset mid-run with a lap stored, then restart with START held
    mode1 = M1_TIMER; mode2 = M2_TIMER_START;
    lap_at(tt(0, 0, 2));
    wait_main(tt(0, 3, 5), 500, "mid_run_wait");
    reset = 1'b1;
    step(1);
    sb.delete();
    check("midrst_time", main_time, tt(0, 0, 0));
    check("midrst_head", lap_head, tt(0, 0, 0));
    check("midrst_valid", lap_valid, 1'b0);
    check("midrst_count", lap_count, 0);
    check("midrst_full", lap_full, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    reset = 1'b0;
    step(10);
    check("restart_pre", main_time, tt(0, 0, 0));
    step(1);
    check("restart_tick", main_time, tt(0, 0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
